unified_mem_arbiter: RTL and testbench

- Arbitrates the instruction-fetch port and the memory-stage load/store port onto one shared single-ported memory bus. Permits one outstanding transaction at a time.
- Sits between `instruction_fetch` / `instruction_memory_stage` and the memory. Its stall outputs feed the pipeline in the same way as `load_stall`.
- A fetch that is in flight when a branch redirect arrives is discarded silently.

---
 rtl/unified_mem_arbiter_if.sv | 51 +++++
 rtl/unified_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch, load/store and shared memory bus signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the pipeline-plus-memory side.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_stall_o;
  logic                  flush_i;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [BeWidth-1:0]    dm_be_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic                  dm_rvalid_o;
  logic [DATA_WIDTH-1:0] dm_rdata_o;
  logic                  dm_stall_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [BeWidth-1:0]    mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_rvalid_o, if_rdata_o, if_stall_o,
    output dm_rvalid_o, dm_rdata_o, dm_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_rvalid_o, if_rdata_o, if_stall_o,
    input  dm_rvalid_o, dm_rdata_o, dm_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store,
// one outstanding transaction at a time, with a starvation guard for fetch.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic OwnerData  = 1'b0;
  localparam logic OwnerFetch = 1'b1;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  flushed_q, flushed_d;
  logic [3:0]            starve_q, starve_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [BeWidth-1:0]    mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  fetch_force;
  logic                  if_rvalid, dm_rvalid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    flushed_d   = flushed_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    // Fetch has waited through STARVE_LIMIT data grants and now wins outright.
    fetch_force = bus.if_req_i && (starve_q == StarveMax);

    case (state_q)
      StIdle: begin
        if (bus.dm_req_i && !fetch_force) begin
          owner_d     = OwnerData;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_be_d    = bus.dm_be_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          state_d     = StReq;
          if (bus.if_req_i) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
        end else if (bus.if_req_i) begin
          owner_d     = OwnerFetch;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
          starve_d    = '0;
          state_d     = StReq;
        end else begin
          starve_d = '0;
        end
      end
      StReq: begin
        if (bus.flush_i && owner_q == OwnerFetch) flushed_d = 1'b1;
        if (bus.mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (bus.flush_i && owner_q == OwnerFetch) flushed_d = 1'b1;
        if (bus.mem_rvalid_i) begin
          if (owner_q == OwnerFetch) begin
            if_rdata_d = bus.mem_rdata_i;
          end else begin
            dm_rdata_d = bus.mem_rdata_i;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        flushed_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      owner_q     <= OwnerData;
      flushed_q   <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      flushed_q   <= flushed_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // A redirect arriving in the response cycle itself still kills the fetch pulse.
  always_comb begin
    if_rvalid = (state_q == StResp) && (owner_q == OwnerFetch) && !flushed_q && !bus.flush_i;
    dm_rvalid = (state_q == StResp) && (owner_q == OwnerData);
  end

  assign bus.if_rvalid_o = if_rvalid;
  assign bus.dm_rvalid_o = dm_rvalid;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  // Stalls are forced low while reset is held so every output reads zero.
  assign bus.if_stall_o  = rst_i & bus.if_req_i & ~if_rvalid;
  assign bus.dm_stall_o  = rst_i & bus.dm_req_i & ~dm_rvalid;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: random requesters and memory, checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_unified_mem_arbiter;
  localparam int unsigned StarveLimit = 4;
  localparam int          Never       = 1 << 30;

  logic clk;
  logic rst_n;

  unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(StarveLimit)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus knobs, in percent per cycle.
  int p_if, p_dm, p_gnt, p_flush;

  // Memory contents seen by both ports.
  logic [31:0] mem_arr [16];

  // Transaction-level reference state.
  int          cyc;
  bit          m_busy, m_req, m_owner_f, m_flushed;
  int          m_issue, m_resp, m_rv_cyc, m_free, m_starve;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  bit          if_known;
  bit          saw_if_rv, saw_dm_rv, saw_flush, in_wait;
  int          n_fetch_done, n_data_done, n_forced;

  function automatic logic [31:0] rand_addr();
    return 32'h200 + ($urandom_range(15) << 2);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_flushed = 0; m_owner_f = 0;
    m_issue = Never; m_resp = Never; m_rv_cyc = Never;
    m_free = cyc; m_starve = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0; if_known = 1;
    saw_if_rv = 0; saw_dm_rv = 0; saw_flush = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_mem_be", bus.mem_be_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_wdata", bus.mem_wdata_o, 0);
    check("rst_if_rvalid", bus.if_rvalid_o, 0);
    check("rst_dm_rvalid", bus.dm_rvalid_o, 0);
    check("rst_if_rdata", bus.if_rdata_o, 0);
    check("rst_dm_rdata", bus.dm_rdata_o, 0);
    check("rst_if_stall", bus.if_stall_o, 0);
    check("rst_dm_stall", bus.dm_stall_o, 0);
  endtask

  task automatic start_txn();
    m_busy = 1; m_req = 1; m_flushed = 0;
    m_issue = cyc + 1; m_resp = Never; m_rv_cyc = Never;
  endtask

  // Called mid-cycle: compare outputs for cycle 'cyc', then advance the model.
  task automatic model_step();
    bit resp_now, exp_ifv, exp_dmv, force_f;
    int d;
    in_wait  = m_busy && !m_req && (m_rv_cyc != Never) && (cyc <= m_rv_cyc);
    resp_now = m_busy && (cyc == m_resp);
    exp_ifv  = resp_now && m_owner_f && !m_flushed && !bus.flush_i;
    exp_dmv  = resp_now && !m_owner_f;
    if (resp_now && m_owner_f && !exp_ifv) if_known = 0;

    check("mem_req", bus.mem_req_o, m_req);
    if (m_req) begin
      check("mem_addr", bus.mem_addr_o, m_addr);
      check("mem_we", bus.mem_we_o, m_we);
      check("mem_be", bus.mem_be_o, m_be);
      if (m_we) check("mem_wdata", bus.mem_wdata_o, m_wdata);
    end
    check("if_rvalid", bus.if_rvalid_o, exp_ifv);
    check("dm_rvalid", bus.dm_rvalid_o, exp_dmv);
    check("dm_rdata", bus.dm_rdata_o, exp_dm_rdata);
    if (if_known) check("if_rdata", bus.if_rdata_o, exp_if_rdata);
    check("if_stall", bus.if_stall_o, bus.if_req_i && !exp_ifv);
    check("dm_stall", bus.dm_stall_o, bus.dm_req_i && !exp_dmv);

    saw_if_rv = exp_ifv;
    saw_dm_rv = exp_dmv;
    saw_flush = bus.flush_i;

    if (m_busy && m_owner_f && bus.flush_i && cyc >= m_issue && cyc < m_resp) m_flushed = 1;

    if (m_req && bus.mem_gnt_i) begin
      m_req    = 0;
      d        = $urandom_range(3, 1);
      m_rv_cyc = cyc + d;
      m_resp   = m_rv_cyc + 1;
      if (m_we) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[b]) mem_arr[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end
        m_rdata = $urandom;
      end else begin
        m_rdata = mem_arr[m_addr[5:2]];
      end
    end

    if (m_busy && cyc == m_rv_cyc) begin
      if (m_owner_f) begin
        exp_if_rdata = m_rdata;
        if_known     = !m_flushed;
      end else begin
        exp_dm_rdata = m_rdata;
      end
    end

    if (resp_now) begin
      if (m_owner_f) n_fetch_done++;
      else n_data_done++;
      m_busy = 0; m_flushed = 0; m_free = cyc + 1;
      m_resp = Never; m_rv_cyc = Never;
    end else if (!m_busy && cyc >= m_free) begin
      force_f = bus.if_req_i && (m_starve == StarveLimit);
      if (bus.dm_req_i && !force_f) begin
        m_owner_f = 0; m_we = bus.dm_we_i; m_be = bus.dm_be_i;
        m_addr = bus.dm_addr_i; m_wdata = bus.dm_wdata_i;
        m_starve = bus.if_req_i ? ((m_starve + 1 > StarveLimit) ? StarveLimit : m_starve + 1) : 0;
        start_txn();
      end else if (bus.if_req_i) begin
        if (force_f && bus.dm_req_i) n_forced++;
        m_owner_f = 1; m_we = 0; m_be = 4'hF; m_addr = bus.if_addr_i; m_wdata = '0;
        m_starve = 0;
        start_txn();
      end else begin
        m_starve = 0;
      end
    end
    cyc++;
  endtask

  // Called just after a rising edge: drive inputs for cycle 'cyc'.
  task automatic drive();
    bit rv;
    rv = m_busy && (cyc == m_rv_cyc);
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rv ? m_rdata : $urandom;
    bus.mem_gnt_i    = rv ? 1'b0 : ($urandom_range(99) < p_gnt);
    if (!bus.if_req_i || saw_if_rv || saw_flush) begin
      bus.if_req_i  = ($urandom_range(99) < p_if);
      bus.if_addr_i = rand_addr();
    end
    if (!bus.dm_req_i || saw_dm_rv) begin
      bus.dm_req_i   = ($urandom_range(99) < p_dm);
      bus.dm_we_i    = $urandom_range(1);
      bus.dm_be_i    = 4'($urandom_range(15, 1));
      bus.dm_addr_i  = rand_addr();
      bus.dm_wdata_i = $urandom;
    end
    bus.flush_i = ($urandom_range(99) < p_flush);
  endtask

  task automatic clear_inputs();
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.flush_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_be_i = '0;
    bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic set_knobs(input int pi, input int pd, input int pg, input int pf);
    p_if = pi; p_dm = pd; p_gnt = pg; p_flush = pf;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
    n_fetch_done = 0; n_data_done = 0; n_forced = 0;
    cyc = 0;
    set_knobs(0, 0, 0, 0);
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    set_knobs(40, 40, 60, 5);
    run(400);
    // Both requesters saturated: exercises the starvation override.
    set_knobs(100, 100, 100, 0);
    run(200);
    set_knobs(50, 50, 15, 10);
    run(300);

    // Reset while a transaction waits for its response.
    set_knobs(50, 50, 100, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      model_step();
      if (in_wait) begin
        found = 1;
      end else begin
        @(posedge clk);
        #1;
        drive();
      end
    end
    check("wait_reached", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_knobs(0, 0, 100, 0);
    run(10);

    set_knobs(40, 40, 60, 5);
    run(300);

    check("fetches_done", n_fetch_done > 0, 1);
    check("loads_stores_done", n_data_done > 0, 1);
    check("starve_override_seen", n_forced > 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
